dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the 5-stage pipeline's MEM stage and a debug/loader port.
- Sequences multi-cycle reads and drives a stall into the pipeline hazard logic while the CPU's access cannot complete.
- CPU has priority. A starvation counter guarantees the debug port forward progress.
- Sits between the MEM stage and dmem; dmem RAM is word-addressed.

Parameters:
- ADDR_W, 6: word-address width driven to dmem (64 words).
- MEM_LAT, 1: dmem read latency in cycles, >=1; writes commit in the issue cycle.
- STARVE_MAX, 4: consecutive denied debug-valid cycles before debug is forced ahead of the CPU.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cpu_req_i  in  1  MEM-stage instruction is lw/sw
- cpu_we_i  in  1  1=sw, 0=lw
- cpu_addr_i  in  32  byte address (aluout_m)
- cpu_wdata_i  in  32  store data (writedata_m)
- cpu_rdata_o  out  32  load data, valid when cpu_req_i=1, cpu_we_i=0 and cpu_stall_o=0
- cpu_stall_o  out  1  freeze IF..MEM, bubble WB
- dbg_valid_i  in  1  debug request
- dbg_ready_o  out  1  debug request accepted this cycle
- dbg_we_i  in  1  debug write
- dbg_addr_i  in  32  byte address
- dbg_wdata_i  in  32  debug write data
- dbg_rvalid_o  out  1  one-cycle pulse: dbg_rdata_o valid
- dbg_rdata_o  out  32  debug read data
- mem_en_o  out  1  dmem access strobe
- mem_we_o  out  1  dmem write enable
- mem_addr_o  out  ADDR_W  word address, equal to addr[ADDR_W+1:2]
- mem_wdata_o  out  32  dmem write data
- mem_rdata_i  in  32  dmem read data, valid MEM_LAT cycles after a read strobe

Behaviour:
- States:
  - IDLE.
  - BUSY: read outstanding; lat_cnt counts 1..MEM_LAT-1; owner register holds CPU or DBG.
  - RESP: data cycle.
  - BUSY is skipped when MEM_LAT=1.
- Grant in IDLE:
  - CPU wins when cpu_req_i=1, unless dbg_valid_i=1 and starve_cnt==STARVE_MAX.
  - Otherwise debug wins if dbg_valid_i=1.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, each cycle dbg_valid_i=1 without grant.
  - Clears on a debug grant.
- Any grant drives mem_en_o=1 with the winner's we/addr/wdata in the same cycle (combinational mux).
- dbg_ready_o=1 exactly in IDLE cycles where debug is granted.
- Write grant: committed that cycle, state stays IDLE. A CPU write gives cpu_stall_o=0 (zero stall).
- Read grant at cycle T: go to BUSY, or to RESP if MEM_LAT=1. RESP falls at cycle T+MEM_LAT.
- In RESP, mem_rdata_i is routed combinationally:
  - owner CPU: to cpu_rdata_o, with cpu_stall_o=0, so the pipeline advances.
  - owner DBG: to dbg_rdata_o, with dbg_rvalid_o=1.
- RESP always returns to IDLE. A CPU request held through RESP is treated as satisfied; no reissue.
- cpu_stall_o=1 when either holds:
  - cpu_req_i=1 and (state IDLE with debug granted, or state BUSY, or state RESP with owner DBG);
  - cpu_req_i=1, cpu_we_i=0, and a CPU read is granted in IDLE.
  - Minimum lw cost is therefore MEM_LAT stall cycles.
- No new grant in BUSY or RESP; dbg_ready_o=0 there.
- Address bits [1:0] and bits above ADDR_W+1 are ignored (wrap, no fault).
- Reset, async, any state:
  - state=IDLE, starve_cnt=0, lat_cnt=0, owner=CPU.
  - An outstanding read is dropped; no rvalid pulse follows.
  - All outputs are 0 while reset=1; data outputs read 0.

Optional Feature:
- DMEM_ARB_PERF_EN defined: adds outputs stall_cycles_o[31:0] and dbg_grants_o[31:0].
  - Counters are saturating, async-reset to 0.
  - stall_cycles_o increments on every cpu_stall_o=1 cycle.
  - dbg_grants_o increments on every dbg_ready_o=1 cycle.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_pkg holds:
  - arb_state_t enum {IDLE, BUSY, RESP};
  - arb_owner_t enum {OWN_CPU, OWN_DBG};
  - the word-address slice helper constant.
- One sub-module: dmem_arb_lat_timer, the load/count/done timer for MEM_LAT.
- Grant mux and FSM stay in the top.

Test Plan:
- CPU sw addr 4 data 1, no debug: mem_en=1, we=1, addr=1 same cycle; cpu_stall_o=0; dmem word1=1.
- CPU lw addr 4, MEM_LAT=1: stall=1 one cycle, then stall=0 with cpu_rdata_o=1.
- Repeat with MEM_LAT=3: exactly 3 stall cycles.
- dbg_valid held with cpu_req every cycle, STARVE_MAX=4: debug denied 4 cycles, granted on cycle 5. CPU stalls that cycle. starve_cnt returns to 0.
- Debug read addr 8 with no CPU request: dbg_ready_o at T, dbg_rvalid_o pulse at T+MEM_LAT with stored value. cpu_stall_o stays 0 throughout.
- Assert reset while in BUSY (MEM_LAT=3): state IDLE immediately, no dbg_rvalid_o/RESP afterward, all outputs 0.
- With DMEM_ARB_PERF_EN, scenarios above: stall_cycles_o and dbg_grants_o match counted cycles exactly.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared arbiter state/owner types and the word-address slice position
package mips_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} arb_state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} arb_owner_t;
  localparam int WORD_LSB = 2;
endpackage

// File: rtl/dmem_arb_lat_timer.sv
// dmem_arb_lat_timer: counts 1..MEM_LAT-1 through BUSY and flags the last busy cycle
module dmem_arb_lat_timer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic busy_i,
  output logic done_o
);
  localparam int CW = $clog2(MEM_LAT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = load_i ? CW'(1) : busy_i ? cnt_q + 1'b1 : '0;
  assign done_o = busy_i && cnt_q == CW'(MEM_LAT - 1);
  // latency counter, parked at zero outside a read
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares dmem between MEM stage and debug port; DMEM_ARB_PERF_EN adds stall/grant counters
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_valid_i,
  output logic              dbg_ready_o,
  input  logic              dbg_we_i,
  input  logic [31:0]       dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  output logic              dbg_rvalid_o,
  output logic [31:0]       dbg_rdata_o,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]       stall_cycles_o,
  output logic [31:0]       dbg_grants_o,
`endif
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic live, idle, starved, dbg_win, cpu_win, grant, g_we, rd_grant, lat_done;
  logic resp_cpu, resp_dbg;
  logic [ADDR_W-1:0] g_addr;
  logic [31:0] g_wdata;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{cpu_addr_i[31:ADDR_W+WORD_LSB], cpu_addr_i[WORD_LSB-1:0],
                              dbg_addr_i[31:ADDR_W+WORD_LSB], dbg_addr_i[WORD_LSB-1:0]};

  assign live     = !reset;
  assign idle     = state_q == IDLE;
  assign starved  = starve_q == SW'(STARVE_MAX);
  assign dbg_win  = idle && dbg_valid_i && (!cpu_req_i || starved);
  assign cpu_win  = idle && cpu_req_i && !dbg_win;
  assign grant    = dbg_win || cpu_win;
  assign g_we     = dbg_win ? dbg_we_i : cpu_we_i;
  assign g_addr   = dbg_win ? dbg_addr_i[WORD_LSB +: ADDR_W] : cpu_addr_i[WORD_LSB +: ADDR_W];
  assign g_wdata  = dbg_win ? dbg_wdata_i : cpu_wdata_i;
  assign rd_grant = grant && !g_we;

  dmem_arb_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (rd_grant),
    .busy_i (state_q == BUSY),
    .done_o (lat_done)
  );

  // next state: reads go through BUSY (unless single-cycle latency) to RESP; writes stay IDLE
  always_comb begin
    state_d  = idle ? (rd_grant ? (MEM_LAT == 1 ? RESP : BUSY) : IDLE)
             : state_q == BUSY ? (lat_done ? RESP : BUSY) : IDLE;
    owner_d  = rd_grant ? (dbg_win ? OWN_DBG : OWN_CPU) : owner_q;
    starve_d = dbg_win ? '0 : (dbg_valid_i && !starved) ? starve_q + 1'b1 : starve_q;
  end

  // FSM, read owner and debug starvation registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_CPU;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end

  assign resp_cpu     = live && state_q == RESP && owner_q == OWN_CPU;
  assign resp_dbg     = live && state_q == RESP && owner_q == OWN_DBG;
  assign mem_en_o     = live && grant;
  assign mem_we_o     = live && grant && g_we;
  assign mem_addr_o   = (live && grant) ? g_addr : '0;
  assign mem_wdata_o  = (live && grant) ? g_wdata : '0;
  assign dbg_ready_o  = live && dbg_win;
  assign dbg_rvalid_o = resp_dbg;
  assign dbg_rdata_o  = resp_dbg ? mem_rdata_i : '0;
  assign cpu_rdata_o  = resp_cpu ? mem_rdata_i : '0;
  assign cpu_stall_o  = live && cpu_req_i &&
                        (dbg_win || state_q == BUSY || resp_dbg || (cpu_win && !cpu_we_i));

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_q, grants_q;
  // saturating counters of stall cycles and debug grants
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_q  <= '0;
      grants_q <= '0;
    end else begin
      stall_q  <= stall_q + 32'(cpu_stall_o && !(&stall_q));
      grants_q <= grants_q + 32'(dbg_ready_o && !(&grants_q));
    end
  assign stall_cycles_o = stall_q;
  assign dbg_grants_o   = grants_q;
`endif
endmodule
